// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT path: config handshake, capture trigger, result wait, frame counting.
// Define FFT_BEAT_CHECK_EN to add the result-beat length check and the len_err output.
module fft_frame_ctrl #(
    parameter int FFT_LEN     = 256,
    parameter int CFG_W       = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_flag,
    input  logic             mode_cont,
    input  logic             fft_dir,
    output logic             i_axi4s_cfg_tvalid,
    output logic [CFG_W-1:0] i_axi4s_cfg_tdata,
    input  logic             i_axi4s_cfg_tready,
    output logic             cap_start,
    input  logic             cap_done,
    input  logic             o_axi4s_data_tvalid,
    input  logic             o_axi4s_data_tlast,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
`ifdef FFT_BEAT_CHECK_EN
    output logic             len_err,
`endif
    output logic             err_timeout
);

    if (FFT_LEN < 1 || HOLDOFF_CYC < 1 || CFG_W < 2) begin : g_param_check
        $error("fft_frame_ctrl: FFT_LEN and HOLDOFF_CYC must be >= 1, CFG_W >= 2");
    end

    typedef enum logic [2:0] {IDLE, CFG, CAPTURE, WAIT_OUT, DONE, HOLD} state_t;

    state_t      state;
    logic        running;
    logic        cont;
    logic [15:0] tmr;
    logic        out_exit;
    logic        tmo_hit;
`ifdef FFT_BEAT_CHECK_EN
    logic [15:0] beat_cnt;
`endif

    assign out_exit = o_axi4s_data_tvalid & o_axi4s_data_tlast;
    // One timer serves both timed states and the holdoff; it is cleared on every entry.
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmr == 16'(TIMEOUT_CYC - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            running            <= 1'b0;
            cont               <= 1'b0;
            tmr                <= '0;
            i_axi4s_cfg_tvalid <= 1'b0;
            i_axi4s_cfg_tdata  <= '0;
            cap_start          <= 1'b0;
            frame_done         <= 1'b0;
            frame_cnt          <= '0;
            err_timeout        <= 1'b0;
`ifdef FFT_BEAT_CHECK_EN
            beat_cnt           <= '0;
            len_err            <= 1'b0;
`endif
        end else begin
            cap_start  <= 1'b0;
            frame_done <= 1'b0;
            if (key_flag && state != IDLE)
                running <= 1'b0;

            case (state)
                IDLE: begin
                    if (key_flag) begin
                        running            <= 1'b1;
                        cont               <= mode_cont;
                        err_timeout        <= 1'b0;
`ifdef FFT_BEAT_CHECK_EN
                        len_err            <= 1'b0;
`endif
                        i_axi4s_cfg_tvalid <= 1'b1;
                        i_axi4s_cfg_tdata  <= {{(CFG_W-1){1'b0}}, fft_dir};
                        state              <= CFG;
                    end
                end
                CFG: begin
                    if (i_axi4s_cfg_tvalid && i_axi4s_cfg_tready) begin
                        i_axi4s_cfg_tvalid <= 1'b0;
                        cap_start          <= 1'b1;
                        tmr                <= '0;
                        state              <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cap_done) begin
                        tmr   <= '0;
`ifdef FFT_BEAT_CHECK_EN
                        beat_cnt <= '0;
`endif
                        state <= WAIT_OUT;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        running     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                WAIT_OUT: begin
`ifdef FFT_BEAT_CHECK_EN
                    if (o_axi4s_data_tvalid)
                        beat_cnt <= beat_cnt + 16'd1;
                    if (out_exit && (beat_cnt + 16'd1 != 16'(FFT_LEN)))
                        len_err <= 1'b1;
`endif
                    if (out_exit) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= DONE;
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        running     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                DONE: begin
                    // A stop pulse landing on this cycle must not let another frame start.
                    if (running && cont && !key_flag) begin
                        tmr   <= '0;
                        state <= HOLD;
                    end else begin
                        running <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    if (!running || key_flag) begin
                        running <= 1'b0;
                        state   <= IDLE;
                    end else if (tmr == 16'(HOLDOFF_CYC - 1)) begin
                        i_axi4s_cfg_tvalid <= 1'b1;
                        i_axi4s_cfg_tdata  <= {{(CFG_W-1){1'b0}}, fft_dir};
                        state              <= CFG;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: expected frame counts queued at tlast, checked at frame_done.
module tb_fft_frame_ctrl;

    localparam int TMO  = 1000;
    localparam int HOLD = 16;
    localparam int LEN  = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_flag = 1'b0;
    logic        mode_cont = 1'b0;
    logic        fft_dir = 1'b0;
    logic        cfg_tready = 1'b0;
    logic        cap_done = 1'b0;
    logic        d_tvalid = 1'b0;
    logic        d_tlast = 1'b0;
    logic        cfg_tvalid;
    logic [7:0]  cfg_tdata;
    logic        cap_start;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_timeout;
`ifdef FFT_BEAT_CHECK_EN
    logic        len_err;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          cap_starts = 0;
    int          frames_seen = 0;
    logic [15:0] exp_cnt = '0;
    logic [15:0] exp_q[$];

    fft_frame_ctrl #(
        .FFT_LEN(LEN), .CFG_W(8), .TIMEOUT_CYC(TMO), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_flag(key_flag),
        .mode_cont(mode_cont),
        .fft_dir(fft_dir),
        .i_axi4s_cfg_tvalid(cfg_tvalid),
        .i_axi4s_cfg_tdata(cfg_tdata),
        .i_axi4s_cfg_tready(cfg_tready),
        .cap_start(cap_start),
        .cap_done(cap_done),
        .o_axi4s_data_tvalid(d_tvalid),
        .o_axi4s_data_tlast(d_tlast),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
`ifdef FFT_BEAT_CHECK_EN
        .len_err(len_err),
`endif
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cap_start) cap_starts++;
            if (frame_done) begin
                frames_seen++;
                if (exp_q.size() == 0) check("frame_done_unexpected", 32'(frame_done), 32'd0);
                else check("frame_cnt", 32'(frame_cnt), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key_pulse();
        key_flag = 1'b1; step(1); key_flag = 1'b0;
    endtask

    task automatic cap_done_pulse();
        cap_done = 1'b1; step(1); cap_done = 1'b0;
    endtask

    task automatic tlast_pulse();
        d_tvalid = 1'b1; d_tlast = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back(exp_cnt);
        step(1);
        d_tvalid = 1'b0; d_tlast = 1'b0;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return cap_start;
            1:       return cfg_tvalid;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int bound);
        int n = 0;
        while (!sig_of(which) && n < bound) begin
            step(1);
            n++;
        end
        if (n >= bound) check({tag, "_wait_expired"}, 32'(sig_of(which)), 32'd1);
    endtask

`ifdef FFT_BEAT_CHECK_EN
    task automatic send_beats(input int n);
        for (int i = 0; i < n - 1; i++) begin
            d_tvalid = 1'b1; step(1);
        end
        d_tvalid = 1'b0;
        tlast_pulse();
    endtask
`endif

    initial begin
        int s0;
        int d;
        int c0;

        // Reset state
        step(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_tvalid", 32'(cfg_tvalid), 32'd0);
        check("rst_cfg_tdata", 32'(cfg_tdata), 32'd0);
        check("rst_cap_start", 32'(cap_start), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single shot
        mode_cont = 1'b0; fft_dir = 1'b1; cfg_tready = 1'b1;
        key_pulse();
        check("ss_cfg_tvalid", 32'(cfg_tvalid), 32'd1);
        check("ss_cfg_tdata", 32'(cfg_tdata), 32'h01);
        step(1);
        check("ss_cap_start", 32'(cap_start), 32'd1);
        step(300);
        cap_done_pulse();
        step(600);
        tlast_pulse();
        check("ss_done_state_busy", 32'(busy), 32'd1);
        step(1);
        check("ss_idle_busy", 32'(busy), 32'd0);
        step(5);
        check("ss_cap_starts", 32'(cap_starts), 32'd1);
        check("ss_frames", 32'(frames_seen), 32'd1);

        // Config backpressure, cap_done coincident with cap_start, tlast without tvalid
        cfg_tready = 1'b0; fft_dir = 1'b1;
        key_pulse();
        fft_dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_tvalid_hold", 32'(cfg_tvalid), 32'd1);
            check("bp_tdata_hold", 32'(cfg_tdata), 32'h01);
            step(1);
        end
        check("bp_no_cap_start", 32'(cap_start), 32'd0);
        cfg_tready = 1'b1;
        step(1);
        check("bp_cap_start_lat", 32'(cap_start), 32'd1);
        check("bp_tvalid_drop", 32'(cfg_tvalid), 32'd0);
        cap_done = 1'b1; step(1); cap_done = 1'b0;
        d_tlast = 1'b1; step(3); d_tlast = 1'b0;
        check("bp_tlast_no_tvalid_frames", 32'(frames_seen), 32'd1);
        check("bp_tlast_no_tvalid_busy", 32'(busy), 32'd1);
        tlast_pulse();
        step(2);
        check("bp_frames", 32'(frames_seen), 32'd2);
        check("bp_idle", 32'(busy), 32'd0);

        // Continuous with stop during frame 3
        s0 = cap_starts;
        mode_cont = 1'b1;
        key_pulse();
        mode_cont = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_for("cont_cap", 0, 100);
            step(5);
            if (f == 2) key_pulse();
            cap_done_pulse();
            step(5);
            tlast_pulse();
            d = cyc;
            if (f < 2) begin
                wait_for("cont_cfg", 1, 100);
                check("holdoff_gap", 32'(cyc - d), 32'(HOLD + 1));
            end
        end
        step(60);
        check("cont_cap_starts", 32'(cap_starts - s0), 32'd3);
        check("cont_idle", 32'(busy), 32'd0);
        check("cont_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Timeout in CAPTURE
        s0 = frames_seen;
        key_pulse();
        wait_for("tmo_cap", 0, 10);
        c0 = cyc;
        step(TMO - 1);
        check("tmo_not_yet", 32'(err_timeout), 32'd0);
        check("tmo_still_busy", 32'(busy), 32'd1);
        step(1);
        check("tmo_err", 32'(err_timeout), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_cycle", 32'(cyc - c0), 32'(TMO));
        step(3);
        check("tmo_sticky", 32'(err_timeout), 32'd1);
        check("tmo_cnt_same", 32'(frame_cnt), 32'(exp_cnt));
        check("tmo_no_frame", 32'(frames_seen - s0), 32'd0);
        key_pulse();
        check("tmo_err_clear", 32'(err_timeout), 32'd0);
        wait_for("tmo_cap2", 0, 10);
        cap_done_pulse();
        tlast_pulse();
        step(2);

`ifdef FFT_BEAT_CHECK_EN
        // Result beat length check
        key_pulse();
        wait_for("len_cap_a", 0, 10);
        cap_done_pulse();
        send_beats(LEN - 1);
        check("len_short_err", 32'(len_err), 32'd1);
        check("len_short_done", 32'(frame_done), 32'd1);
        step(2);
        key_pulse();
        check("len_err_clear", 32'(len_err), 32'd0);
        wait_for("len_cap_b", 0, 10);
        cap_done_pulse();
        send_beats(LEN);
        check("len_exact_err", 32'(len_err), 32'd0);
        check("len_exact_done", 32'(frame_done), 32'd1);
        step(2);
`endif

        // Counter wrap with stop in the DONE cycle
        force dut.frame_cnt = 16'hFFFF;
        step(1);
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        mode_cont = 1'b1;
        key_pulse();
        mode_cont = 1'b0;
        wait_for("wrap_cap", 0, 10);
        cap_done_pulse();
        step(2);
        tlast_pulse();
        s0 = cap_starts;
        key_pulse();
        check("wrap_stop_idle", 32'(busy), 32'd0);
        step(40);
        check("wrap_cnt", 32'(frame_cnt), 32'h0000);
        check("wrap_no_restart", 32'(cap_starts - s0), 32'd0);

        // Reset mid-frame
        mode_cont = 1'b1;
        key_pulse();
        wait_for("mrst_cap", 0, 10);
        step(3);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_cnt", 32'(frame_cnt), 32'd0);
        step(2);
        rst_n = 1'b1;
        exp_cnt = '0;
        s0 = cap_starts;
        step(30);
        check("mrst_no_cap_start", 32'(cap_starts - s0), 32'd0);
        check("mrst_idle", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
